// File: rtl/module_branch_resolve.sv
// Branch resolution for the gselect predictor: in-order prediction queue,
// predictor update strobe, mispredict redirect and saturating statistics.
module module_branch_resolve #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    output logic             pred_ready,
    input  logic [31:0]      pred_pc,
    input  logic             pred_taken,
    input  logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             update,
    output logic [31:0]      branchPC,
    output logic [31:0]      resultPC,
    output logic             taken,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]      pc_q  [DEPTH];
    logic [31:0]      tgt_q [DEPTH];
    logic [DEPTH-1:0] tk_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic             update_q, taken_q, redirect_q;
    logic [31:0]      branch_pc_q, result_pc_q, redirect_pc_q;
    logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

    logic [31:0] head_pc, head_tgt;
    logic        head_tk;
    logic        match, mispred, push, pop;
    logic [31:0] corr_npc, pred_npc;

    assign pred_ready = (count_q != FULL);
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_tgt   = tgt_q[rd_ptr_q];
    assign head_tk    = tk_q[rd_ptr_q];

    always_comb begin
        match    = (count_q != '0) && (head_pc == ex_pc);
        corr_npc = ex_taken ? ex_target : ex_pc + 32'd4;
        pred_npc = head_tk ? head_tgt : head_pc + 32'd4;
        mispred  = ex_valid && (!match || (pred_npc != corr_npc));
        pop      = ex_valid && !mispred;
        // Fetch pushes in a flush cycle are wrong-path and get dropped.
        push     = pred_valid && pred_ready && !mispred;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (mispred) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]  <= pred_pc;
            tgt_q[wr_ptr_q] <= pred_target;
            tk_q[wr_ptr_q]  <= pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            update_q         <= 1'b0;
            taken_q          <= 1'b0;
            redirect_q       <= 1'b0;
            branch_pc_q      <= '0;
            result_pc_q      <= '0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            update_q   <= ex_valid;
            redirect_q <= mispred;
            if (ex_valid) begin
                branch_pc_q <= ex_pc;
                result_pc_q <= ex_target;
                taken_q     <= ex_taken;
            end
            if (mispred)
                redirect_pc_q <= corr_npc;
            if (ex_valid && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispred && (mispredict_cnt_q != '1))
                mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
        end
    end

    assign update         = update_q;
    assign branchPC       = branch_pc_q;
    assign resultPC       = result_pc_q;
    assign taken          = taken_q;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: doc/module_branch_resolve.md
# module_branch_resolve

Resolution side of the gselect predictor. Holds the predictions made at fetch in an in-order queue and compares each one with the outcome computed in execute. For every resolved branch it drives the predictor's update port: `update`, `branchPC`, `resultPC` and `taken`. On a wrong next-PC it raises a one-cycle redirect/flush to fetch and keeps misprediction statistics.

## Interface
- `DEPTH`, default 4: in-flight prediction queue entries; power of 2, ≥2.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `pred_valid`  in  1: fetch pushes a prediction for a branch-type instruction.
- `pred_ready`  out  1: queue can accept a push. Equals `count != DEPTH`.
- `pred_pc`  in  32: PC of the predicted branch.
- `pred_taken`  in  1: predicted direction.
- `pred_target`  in  32: predicted target.
- `ex_valid`  in  1: execute resolves one branch this cycle.
- `ex_pc`  in  32: PC of the resolved branch.
- `ex_taken`  in  1: actual direction.
- `ex_target`  in  32: actual target.
- `update`  out  1: one-cycle predictor update strobe.
- `branchPC`  out  32: resolved branch PC.
- `resultPC`  out  32: actual target (`ex_target`).
- `taken`  out  1: actual direction.
- `redirect`  out  1: one-cycle mispredict/flush pulse to fetch.
- `redirect_pc`  out  32: correct next PC.
- `branch_cnt`  out  CNT_W: resolved branches, saturating.
- `mispredict_cnt`  out  CNT_W: mispredictions, saturating.

## Operation
- Queue: circular FIFO of {pc, taken, target}. Write and read pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits.
- Push occurs when `pred_valid && pred_ready`.
- Resolve occurs on any `ex_valid`. The head entry is a match when `count != 0` and head.pc == `ex_pc`.
- Correct next PC: `ex_taken ? ex_target : ex_pc + 4` (32-bit modulo add; wraps at 0xFFFFFFFC).
- Predicted next PC on a match: `head.taken ? head.target : head.pc + 4`.
- Mispredict when there is a match and the two next PCs differ. Also mispredict when there is no match (queue empty, or PC mismatch = unpredicted branch).
- Matched and correct: pop head.
- Mispredict: flush the whole queue (count := 0, both pointers := 0). All younger entries are wrong-path.
- Every resolve produces `update`. `branchPC`=`ex_pc`, `resultPC`=`ex_target`, `taken`=`ex_taken`, whether or not the prediction was correct.
- Push in the same cycle as a flush: push is dropped (wrong-path).
- Push and correct pop in the same cycle: both occur, count unchanged. At full, `pred_ready`=0, so no push happens even if a pop occurs.
- Counters: `branch_cnt` increments on every resolve; `mispredict_cnt` increments on every mispredict. Both hold at all-ones.

## Timing
- Reset (`rst`=0 at a clk edge): count, pointers, `update`, `redirect`, `taken`, `branchPC`, `resultPC`, `redirect_pc`, `branch_cnt` and `mispredict_cnt` all go to 0. `pred_ready`=1 after reset. Reset mid-operation discards all queued entries that cycle.
- `update`, `branchPC`, `resultPC`, `taken`, `redirect` and `redirect_pc` are registered. They are valid in the cycle after `ex_valid` (latency 1) and high for exactly one cycle per resolve.
- Back-to-back resolves give back-to-back `update` pulses.
- `redirect_pc` holds its last value when `redirect`=0.
- Queue state and counters update at the same edge that registers the outputs.
- `pred_ready` is combinational from registered `count`; it has no combinational path from `ex_valid`.

## Test plan
- Reset then idle: all outputs 0, `pred_ready`=1. Push 4 predictions → `pred_ready`=0 after the 4th edge; a 5th push is ignored and count stays 4.
- Push {0x100, taken, 0x200}; resolve `ex_pc`=0x100, taken, target 0x200 → next cycle: `update`=1, `branchPC`=0x100, `resultPC`=0x200, `taken`=1, `redirect`=0; queue empty; `branch_cnt`=1.
- Push {0x100, not-taken}, then {0x104, ...}; resolve 0x100 taken→0x300 → `redirect`=1, `redirect_pc`=0x300, queue flushed, `mispredict_cnt`=1, and a push in the same cycle is dropped.
- Push {0x100, taken, 0x200}; resolve 0x100 not-taken → `redirect_pc`=0x104 and mispredict. Resolve `ex_pc`=0xFFFFFFFC not-taken with an empty queue → `redirect_pc`=0x00000000.
- Full queue plus a correct resolve with `pred_valid`=1 in the same cycle → pop only, count goes 4→3; the next cycle's push is accepted.
- Preload `mispredict_cnt` near saturation (CNT_W=4 build) and force 20 mispredicts → counter holds at 15. Assert `rst`=0 with 3 entries queued → count 0, `pred_ready`=1 next cycle.
